fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
- Sequences one spectrum frame end to end: captures N converted audio samples into an internal frame RAM.
- Streams the frame into the FFT sink with sop/eop/valid framing under sink_ready backpressure.
- Collects the first N/2 magnitude results into the display bin buffer, then hands off to the line drawer.
- Sits between the int-to-float stage, the FFT core, the float-to-int stage and the line drawer.
- Replaces ad-hoc per-stage start/done chaining with a single master FSM.

Parameters:
- N, 1024: FFT points per frame; power of two, at least 4.
- DATA_W, 32: sample word width (single-precision float).
- MAG_W, 32: magnitude word width from float-to-int.
- BIN_W, 9: display bin width.
- MAG_SHIFT, 2: right shift applied to magnitude before saturation.
- TIMEOUT, 65536: max idle cycles between magnitudes in COLLECT.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  synchronous active-low reset.
- trigger  in  1  one-cycle frame request (debounced KEY).
- continuous  in  1  auto re-arm after each draw (SW).
- sample_valid  in  1  sample_data valid this cycle (ItoF_done).
- sample_data  in  DATA_W  converted audio sample.
- sink_ready  in  1  FFT accepts input.
- sink_valid  out  1  FFT input valid.
- sink_sop  out  1  first sample of frame.
- sink_eop  out  1  last sample of frame.
- sink_real  out  DATA_W  FFT real input.
- mag_valid  in  1  magnitude result valid (FtoI_done).
- mag_data  in  MAG_W  unsigned magnitude.
- bin_wr_en  out  1  write strobe to bin buffer.
- bin_wr_addr  out  log2(N)-1  bin index, 0..N/2-1.
- bin_wr_data  out  BIN_W  scaled magnitude.
- draw_start  out  1  one-cycle pulse: bins complete.
- draw_done  in  1  line drawer finished.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; a COLLECT timeout occurred.
- state_dbg  out  3  encoded state for LEDR.

Behaviour:
- Reset (reset_n=0 at a clk edge) applies from any state, including mid-stream. Next state is IDLE and all counters clear.
- Outputs after reset: sink_valid=0, sink_sop=0, sink_eop=0, sink_real=0, bin_wr_en=0, bin_wr_addr=0, bin_wr_data=0, draw_start=0, busy=0, timeout_err=0, state_dbg=0.
- State encoding: IDLE=0, CAPTURE=1, STREAM=2, COLLECT=3, DRAW=4.
- IDLE:
  - trigger or continuous -> CAPTURE, with cap_cnt=0.
- CAPTURE:
  - Each sample_valid writes ram[cap_cnt] and increments cap_cnt.
  - The write at cap_cnt==N-1 -> STREAM, with rd_idx=0.
  - sample_valid outside CAPTURE is ignored.
- STREAM:
  - RAM has 1-cycle read latency. The output register is prefetched so sink_valid rises 1 cycle after STREAM entry, then stays high until the frame completes.
  - A sample transfers when sink_valid && sink_ready; only then does rd_idx advance.
  - While sink_ready=0, sink_real, sop and eop hold unchanged.
  - sink_sop=1 only with word 0; sink_eop=1 only with word N-1.
  - When eop transfers: sink_valid drops next cycle -> COLLECT, with bin_cnt=0 and wdog=0.
- COLLECT:
  - On each mag_valid: 1 cycle later, bin_wr_en=1, bin_wr_addr=bin_cnt, bin_wr_data=min(mag_data>>MAG_SHIFT, 2^BIN_W-1). Then bin_cnt increments.
  - When the write with bin_cnt==N/2-1 occurs -> DRAW. draw_start pulses exactly 1 cycle, on the cycle after that write.
  - mag_valid arriving after bin N/2-1 (mirror half) is ignored.
  - wdog counts cycles without mag_valid and resets on each one. At wdog==TIMEOUT-1: set timeout_err -> IDLE, with no draw_start.
- DRAW:
  - draw_done -> CAPTURE if continuous=1, else IDLE.
  - draw_done outside DRAW is ignored.
- trigger outside IDLE is ignored; it is not queued.
- continuous deasserted mid-frame: the current frame completes, then the FSM returns to IDLE.
- timeout_err clears only on reset.

Optional Feature:
FFT_FRAME_SEQ_STATS_EN
- Defined: adds outputs frame_count[15:0] and dropped_samples[15:0].
  - frame_count increments on each draw_start and wraps.
  - dropped_samples increments on each sample_valid received outside CAPTURE, saturating at 16'hFFFF.
  - Both counters clear on reset.
- Undefined: neither port nor either counter exists; behaviour is otherwise identical.

Test Plan:
1. N=8, trigger pulse, 8 samples 1..8 with gaps, sink_ready=1 -> sink_real sequence 1..8 on consecutive cycles; sop with 1, eop with 8; busy=1 from the cycle after trigger.
2. STREAM with sink_ready toggling 1,0,0,1 -> no word dropped or duplicated; outputs held while sink_ready=0; exactly 8 transfers.
3. COLLECT with mag_data 0, 4, 8, 4096 (BIN_W=9, MAG_SHIFT=2) -> bin_wr_data 0, 1, 2, 511 at addresses 0..3; draw_start pulses once after addr 3; mag_valid 5..8 produce no writes.
4. continuous=1, draw_done pulse -> state_dbg 4 -> 1 with no IDLE visit; a trigger pulse in CAPTURE is ignored.
5. TIMEOUT=16, only 2 mag_valid in COLLECT -> after 16 quiet cycles: timeout_err=1, state IDLE, no draw_start.
6. reset_n=0 for 1 cycle mid-STREAM -> next cycle all outputs at reset values, state_dbg=0; a new trigger starts with sink_sop on word 0.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: one master FSM that captures, streams, collects and draws one spectrum frame.
//   Optional macro FFT_FRAME_SEQ_STATS_EN adds frame_count and dropped_samples outputs.
//   Ports: clk/reset_n (sync, active-low); trigger/continuous start a frame;
//   sample_valid/sample_data feed the frame RAM; sink_* stream the frame into the FFT;
//   mag_valid/mag_data return magnitudes; bin_wr_* write scaled bins; draw_start/draw_done
//   hand off to the line drawer; busy/timeout_err/state_dbg report status.
module fft_frame_sequencer #(
  parameter int N         = 1024,
  parameter int DATA_W    = 32,
  parameter int MAG_W     = 32,
  parameter int BIN_W     = 9,
  parameter int MAG_SHIFT = 2,
  parameter int TIMEOUT   = 65536
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    trigger,
  input  logic                    continuous,
  input  logic                    sample_valid,
  input  logic [DATA_W-1:0]       sample_data,
  input  logic                    sink_ready,
  output logic                    sink_valid,
  output logic                    sink_sop,
  output logic                    sink_eop,
  output logic [DATA_W-1:0]       sink_real,
  input  logic                    mag_valid,
  input  logic [MAG_W-1:0]        mag_data,
  output logic                    bin_wr_en,
  output logic [$clog2(N)-2:0]    bin_wr_addr,
  output logic [BIN_W-1:0]        bin_wr_data,
  output logic                    draw_start,
  input  logic                    draw_done,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [2:0]              state_dbg
`ifdef FFT_FRAME_SEQ_STATS_EN
  ,
  output logic [15:0]             frame_count,
  output logic [15:0]             dropped_samples
`endif
);
  localparam int AW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(N - 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);
  localparam logic [MAG_W-1:0] BIN_MAX = MAG_W'((1 << BIN_W) - 1);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    STREAM  = 3'd2,
    COLLECT = 3'd3,
    DRAW    = 3'd4
  } state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] ram [N];
  logic [AW-1:0] cap_cnt, rd_idx, rd_nxt;
  logic [AW-2:0] bin_cnt;
  logic [WW-1:0] wdog;
  logic [MAG_W-1:0] mag_sh;
  logic cap_wr, xfer, mag_acc, wd_exp;
  assign cap_wr    = state == CAPTURE && sample_valid;
  assign xfer      = sink_valid && sink_ready;
  assign rd_nxt    = rd_idx + 1'b1;
  assign mag_acc   = state == COLLECT && mag_valid;
  assign wd_exp    = state == COLLECT && !mag_valid && wdog == WD_LIMIT;
  assign mag_sh    = mag_data >> MAG_SHIFT;
  assign busy      = state != IDLE;
  assign state_dbg = state;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (trigger || continuous) ? CAPTURE : IDLE;
      CAPTURE: state_n = (cap_wr && cap_cnt == LAST_WORD) ? STREAM : CAPTURE;
      STREAM:  state_n = (xfer && sink_eop) ? COLLECT : STREAM;
      COLLECT: state_n = (mag_acc && &bin_cnt) ? DRAW : wd_exp ? IDLE : COLLECT;
      DRAW:    state_n = draw_done ? (continuous ? CAPTURE : IDLE) : DRAW;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (cap_wr) ram[cap_cnt] <= sample_data;
  end
  // The output register is loaded once on STREAM entry (prefetch of word 0) and then
  // on every transfer with the following word, so words go out back to back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_cnt     <= '0;
      rd_idx      <= '0;
      bin_cnt     <= '0;
      wdog        <= '0;
      sink_valid  <= 1'b0;
      sink_sop    <= 1'b0;
      sink_eop    <= 1'b0;
      sink_real   <= '0;
      bin_wr_en   <= 1'b0;
      bin_wr_addr <= '0;
      bin_wr_data <= '0;
      draw_start  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cap_cnt <= (state == CAPTURE) ? cap_cnt + AW'(sample_valid) : '0;
      if (state != STREAM) begin
        rd_idx     <= '0;
        sink_valid <= 1'b0;
        sink_sop   <= 1'b0;
        sink_eop   <= 1'b0;
      end else if (!sink_valid) begin
        sink_valid <= 1'b1;
        sink_sop   <= 1'b1;
        sink_real  <= ram[rd_idx];
      end else if (sink_ready) begin
        sink_valid <= !sink_eop;
        sink_sop   <= 1'b0;
        sink_eop   <= rd_nxt == LAST_WORD;
        rd_idx     <= rd_nxt;
        sink_real  <= ram[rd_nxt];
      end
      bin_wr_en <= mag_acc;
      if (mag_acc) begin
        bin_wr_addr <= bin_cnt;
        bin_wr_data <= (mag_sh > BIN_MAX) ? '1 : mag_sh[BIN_W-1:0];
      end
      bin_cnt     <= (state != COLLECT) ? '0 : mag_valid ? bin_cnt + 1'b1 : bin_cnt;
      wdog        <= (state != COLLECT || mag_valid) ? '0 : wdog + 1'b1;
      timeout_err <= timeout_err | wd_exp;
      // Only the final bin write lands while already in DRAW, so this fires once per frame.
      draw_start  <= state == DRAW && bin_wr_en;
    end
  end
`ifdef FFT_FRAME_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_count     <= '0;
      dropped_samples <= '0;
    end else begin
      if (draw_start) frame_count <= frame_count + 1'b1;
      if (sample_valid && state != CAPTURE && dropped_samples != 16'hFFFF)
        dropped_samples <= dropped_samples + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: randomized directed bench for fft_frame_sequencer with a frame-level reference model.
module tb_fft_frame_sequencer;
  localparam int N = 8;
  localparam int TO = 16;
  logic clk = 1'b0, reset_n = 1'b0, trigger = 1'b0, continuous = 1'b0;
  logic sample_valid = 1'b0, sink_ready = 1'b0, mag_valid = 1'b0, draw_done = 1'b0;
  logic [31:0] sample_data = '0, mag_data = '0;
  logic sink_valid, sink_sop, sink_eop, bin_wr_en, draw_start, busy, timeout_err;
  logic [31:0] sink_real;
  logic [1:0] bin_wr_addr;
  logic [8:0] bin_wr_data;
  logic [2:0] state_dbg;
`ifdef FFT_FRAME_SEQ_STATS_EN
  logic [15:0] frame_count, dropped_samples;
`endif
  int total = 0, bad = 0;
  logic [31:0] frame [N];
  always #5 clk = ~clk;
  fft_frame_sequencer #(.N(N), .DATA_W(32), .MAG_W(32), .BIN_W(9), .MAG_SHIFT(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .continuous(continuous),
    .sample_valid(sample_valid), .sample_data(sample_data), .sink_ready(sink_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real),
    .mag_valid(mag_valid), .mag_data(mag_data), .bin_wr_en(bin_wr_en), .bin_wr_addr(bin_wr_addr),
    .bin_wr_data(bin_wr_data), .draw_start(draw_start), .draw_done(draw_done), .busy(busy),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
`ifdef FFT_FRAME_SEQ_STATS_EN
    , .frame_count(frame_count), .dropped_samples(dropped_samples)
`endif
  );
  function automatic logic [8:0] sat(input logic [31:0] m);
    logic [31:0] s;
    s = m >> 2;
    return (s > 32'd511) ? 9'd511 : s[8:0];
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_valid", sink_valid, 0);
    chk("rst_sop", sink_sop, 0);
    chk("rst_eop", sink_eop, 0);
    chk("rst_real", sink_real, 0);
    chk("rst_bin_en", bin_wr_en, 0);
    chk("rst_bin_addr", bin_wr_addr, 0);
    chk("rst_bin_data", bin_wr_data, 0);
    chk("rst_draw", draw_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_state", state_dbg, 0);
  endtask
  task automatic capture();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        sample_valid = 1'b0;
      end
      @(negedge clk);
      chk("cap_state", state_dbg, 1);
      frame[i] = $urandom;
      sample_valid = 1'b1;
      sample_data = frame[i];
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk("stream_entry_state", state_dbg, 2);
    chk("stream_entry_valid", sink_valid, 0);
  endtask
  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic stream(input int mode);
    int idx;
    logic [3:0] pat;
    idx = 0;
    pat = 4'b1001;
    for (int c = 0; c < 100 && idx < N; c++) begin
      @(negedge clk);
      chk("str_valid", sink_valid, 1);
      chk("str_data", sink_real, frame[idx]);
      chk("str_sop", sink_sop, idx == 0);
      chk("str_eop", sink_eop, idx == N - 1);
      sink_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[c % 4] : 1'($urandom_range(0, 1));
      sample_valid = 1'($urandom_range(0, 1));
      sample_data = $urandom;
      if (sink_ready) idx++;
    end
    chk("str_bound", idx, N);
    @(negedge clk);
    sample_valid = 1'b0;
    sink_ready = 1'b0;
    chk("str_end_valid", sink_valid, 0);
    chk("str_end_state", state_dbg, 3);
  endtask
  task automatic collect(input int nmag, input bit fixed);
    logic [31:0] fv [4];
    logic [31:0] m;
    int sent, acc, gap, paddr;
    bit pend, ds, fin;
    logic [8:0] pdata;
    fv = '{32'd0, 32'd4, 32'd8, 32'd4096};
    sent = 0; acc = 0; gap = 0; paddr = 0; pend = 0; ds = 0; fin = 0; pdata = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      chk("bin_en", bin_wr_en, pend);
      if (pend) begin
        chk("bin_addr", bin_wr_addr, paddr);
        chk("bin_data", bin_wr_data, pdata);
      end
      chk("draw_start", draw_start, ds);
      ds = pend && paddr == N / 2 - 1;
      pend = 0;
      mag_valid = 1'b0;
      if (sent < nmag && gap == 0) begin
        m = (fixed && sent < 4) ? fv[sent] : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 4000));
        mag_valid = 1'b1;
        mag_data = m;
        sent++;
        gap = $urandom_range(0, 3);
        if (acc < N / 2) begin
          pend = 1;
          paddr = acc;
          pdata = sat(m);
          acc++;
        end
      end else if (gap > 0) gap--;
      if (sent == nmag && !mag_valid && !pend && !ds) begin
        fin = 1;
        break;
      end
    end
    chk("col_bound", fin, 1);
  endtask
  task automatic draw(input bit cont);
    @(negedge clk);
    chk("draw_once", draw_start, 0);
    chk("draw_state", state_dbg, 4);
    continuous = cont;
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    chk("after_draw_state", state_dbg, cont ? 3'd1 : 3'd0);
    chk("after_draw_busy", busy, cont);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_reset();
    reset_n = 1'b1;
    sample_valid = 1'b1;
    sample_data = $urandom;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("idle_state", state_dbg, 0);
    chk("idle_busy", busy, 0);
    // frame 1: trigger, full-rate stream, fixed magnitudes, continuous re-arm
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk("trig_busy", busy, 1);
    chk("trig_state", state_dbg, 1);
    capture();
    stream(0);
    collect(N, 1);
    draw(1);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    continuous = 1'b0;
    chk("trig_in_capture", state_dbg, 1);
    // frame 2: continuous dropped mid-frame, ready pattern, random magnitudes
    capture();
    stream(1);
    collect(N, 0);
    draw(0);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    chk("draw_done_idle", state_dbg, 0);
    // frame 3: watchdog timeout after two magnitudes
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    capture();
    stream(2);
    mag_valid = 1'b1;
    mag_data = $urandom;
    @(negedge clk);
    mag_data = $urandom;
    @(negedge clk);
    mag_valid = 1'b0;
    for (int j = 1; j <= TO; j++) begin
      chk("tmo_quiet_err", timeout_err, 0);
      chk("tmo_quiet_state", state_dbg, 3);
      chk("tmo_quiet_draw", draw_start, 0);
      @(negedge clk);
    end
    chk("tmo_err", timeout_err, 1);
    chk("tmo_state", state_dbg, 0);
    chk("tmo_draw", draw_start, 0);
    // frame 4: reset in the middle of streaming
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    capture();
    chk("tmo_sticky", timeout_err, 1);
    sink_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset();
    reset_n = 1'b1;
    sink_ready = 1'b0;
    // frame 5: started by continuous alone, clean run after reset
    continuous = 1'b1;
    @(negedge clk);
    chk("cont_start", state_dbg, 1);
    capture();
    stream(2);
    collect(N, 0);
    draw(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
